// File: rtl/ebi_sched_pkg.sv
// Shared types for the EBI write scheduler: target regions, FSM states,
// the queued-entry header and the address decode helper.
package ebi_sched_pkg;

    localparam int LOCAL_ADDR_W = 14;

    typedef enum logic [1:0] {
        REG_VRAM = 2'd0,
        REG_OAM  = 2'd1,
        REG_PAL  = 2'd2,
        REG_CTRL = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        ISSUE = 2'd3
    } state_e;

    // Queue entry header. The data word rides beside it in the same FIFO
    // word because its width is a module parameter.
    typedef struct packed {
        region_e                  region;
        logic [LOCAL_ADDR_W-1:0]  addr;
    } fifo_entry_t;

    // Region comes from the two top address bits.
    function automatic region_e decode_region(input logic [1:0] addr_hi);
        return region_e'(addr_hi);
    endfunction

    // One-hot target select: [0]VRAM [1]OAM [2]PAL [3]CTRL.
    function automatic logic [3:0] region_onehot(input region_e region);
        return 4'b0001 << region;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push while full is accepted
// only when a pop happens in the same cycle; the head is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ebi_write_scheduler.sv
// EBI write scheduler: queues single-cycle write strobes in order and issues
// them one at a time on a valid/ready bus. Memory targets (VRAM/OAM/PAL)
// issue only during vblank; control writes issue at any time. A blocked
// memory write at the head also holds back everything queued behind it.
//
// Handshake: out_valid rises with out_* stable and they stay unchanged until
// the cycle where tgt_ready is high; the write completes in that cycle.
//
// Optional build macro EBI_SCHED_STATS_EN: enables saturating drop/issue
// counters; without it drop_count and issue_count are tied to zero.
module ebi_write_scheduler
    import ebi_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_strobe,
    input  logic              vblank,
    input  logic              tgt_ready,
    input  logic              ovf_clear,
    output logic              out_valid,
    output logic [3:0]        out_sel,
    output logic [13:0]       out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic [15:0]       issue_count
);

    localparam int ENTRY_W = $bits(fifo_entry_t) + DATA_W;

    state_e            state;
    fifo_entry_t       push_hdr;
    fifo_entry_t       head_hdr;
    logic [DATA_W-1:0] head_data;
    logic [ENTRY_W-1:0] push_word;
    logic [ENTRY_W-1:0] head_word;
    region_e           hold_region;
    logic [13:0]       hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              pop;
    logic              drop;

    assign push_hdr  = '{region: decode_region(wr_addr[15:14]), addr: wr_addr[13:0]};
    assign push_word = {push_hdr, wr_data};
    assign {head_hdr, head_data} = head_word;
    assign pop  = (state == LOAD) && !fifo_empty;
    assign drop = wr_strobe && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_strobe),
        .pop   (pop),
        .din   (push_word),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM. LOAD pops the head into the holding register; when that entry
    // is already eligible the HOLD decision is taken in the same cycle so a
    // write issues every two cycles. HOLD waits for vblank on memory targets.
    // vblank is not looked at in ISSUE, so out_* stay put until tgt_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_sel     <= '0;
            out_addr    <= '0;
            out_data    <= '0;
            hold_region <= REG_VRAM;
            hold_addr   <= '0;
            hold_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    if (fifo_empty) begin
                        state <= IDLE;
                    end else begin
                        hold_region <= head_hdr.region;
                        hold_addr   <= head_hdr.addr;
                        hold_data   <= head_data;
                        if (head_hdr.region == REG_CTRL || vblank) begin
                            state     <= ISSUE;
                            out_valid <= 1'b1;
                            out_sel   <= region_onehot(head_hdr.region);
                            out_addr  <= head_hdr.addr;
                            out_data  <= head_data;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_region == REG_CTRL || vblank) begin
                        state     <= ISSUE;
                        out_valid <= 1'b1;
                        out_sel   <= region_onehot(hold_region);
                        out_addr  <= hold_addr;
                        out_data  <= hold_data;
                    end
                end
                ISSUE: begin
                    if (tgt_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_empty ? IDLE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as ovf_clear wins.
    always_ff @(posedge clk) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end

`ifdef EBI_SCHED_STATS_EN
    logic issue_fire;
    assign issue_fire = out_valid && tgt_ready;

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count  <= '0;
            issue_count <= '0;
        end else begin
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
            if (issue_fire && issue_count != 16'hFFFF)
                issue_count <= issue_count + 1'b1;
        end
    end
`else
    assign drop_count  = '0;
    assign issue_count = '0;
`endif

endmodule
